// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : Shared constants and loader state encoding for the 8-bit MCU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam int MC_IW    = 12;  // program memory word width
    localparam int MC_AW    = 8;   // program memory address width
    localparam int MC_DEPTH = 10;  // largest bootable program

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/pmem_boot_loader.sv
// ============================================================================
// Module : pmem_boot_loader
// Brief  : Streams host instructions into PMem, then clears and releases the core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pmem_boot_loader #(
    parameter int IW    = mc_pkg::MC_IW,
    parameter int AW    = mc_pkg::MC_AW,
    parameter int DEPTH = mc_pkg::MC_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          host_valid,
    input  logic [IW-1:0] host_instr,
    input  logic          host_last,
    output logic          host_ready,
    output logic          pmem_le,
    output logic [AW-1:0] pmem_la,
    output logic [IW-1:0] pmem_li,
    output logic          core_rst,
    output logic          core_clr,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] word_count,
    output logic [IW-1:0] checksum
);

    import mc_pkg::*;

    loader_state_e state;
    loader_state_e state_next;
    logic          xfer;
    logic          start_load;
    logic          at_limit;

    assign xfer     = host_valid & host_ready;
    // True while accepting the last word that still fits in PMem.
    assign at_limit = (word_count == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        host_ready = 1'b0;
        core_rst   = 1'b1;
        core_clr   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                // Ready depends on state only, so the host sees no combinational loop.
                host_ready = 1'b1;
                if (xfer) begin
                    if (host_last) begin
                        state_next = ST_CLEAR;
                    end else if (at_limit) begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_CLEAR: begin
                core_clr   = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (start) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (start_load) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (xfer) begin
            word_count <= word_count + AW'(1);
            checksum   <= checksum ^ host_instr;
        end
    end

    // One-cycle write stage: the final word lands during CLEAR, before the core runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pmem_le <= 1'b0;
            pmem_la <= '0;
            pmem_li <= '0;
        end else begin
            pmem_le <= xfer;
            if (xfer) begin
                pmem_la <= word_count;
                pmem_li <= host_instr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pmem_boot_loader.sv
// ============================================================================
// Module : tb_pmem_boot_loader
// Brief  : Self-checking bench for pmem_boot_loader with a word-list load model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pmem_boot_loader;

    import mc_pkg::*;

    localparam int IW    = MC_IW;
    localparam int AW    = MC_AW;
    localparam int DEPTH = MC_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          host_valid;
    logic [IW-1:0] host_instr;
    logic          host_last;
    logic          host_ready;
    logic          pmem_le;
    logic [AW-1:0] pmem_la;
    logic [IW-1:0] pmem_li;
    logic          core_rst;
    logic          core_clr;
    logic          done;
    logic          err;
    logic [AW-1:0] word_count;
    logic [IW-1:0] checksum;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [IW-1:0] words [DEPTH];
    logic [AW-1:0] exp_count;
    logic [IW-1:0] exp_sum;

    always #5 clk = ~clk;

    pmem_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .host_valid (host_valid),
        .host_instr (host_instr),
        .host_last  (host_last),
        .host_ready (host_ready),
        .pmem_le    (pmem_le),
        .pmem_la    (pmem_la),
        .pmem_li    (pmem_li),
        .core_rst   (core_rst),
        .core_clr   (core_clr),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    // Load the first n entries of words[]; inputs change and outputs are sampled at negedge.
    task automatic do_load(input int n, input bit use_last, input int gap_min,
                           input int gap_max, input bit noisy);
        bit            pend;
        logic [AW-1:0] pa;
        logic [IW-1:0] pd;
        logic [IW-1:0] xs;
        int            g;
        host_valid = 1'b0;
        host_last  = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({host_ready, core_rst, done, err, pmem_le} !== 5'b11000 ||
            word_count !== '0 || checksum !== '0)
            $display("FAIL load_entry: ready/rst/done/err/le=%b cnt=%0d sum=%h required 11000 cnt=0 sum=000",
                     {host_ready, core_rst, done, err, pmem_le}, word_count, checksum);
        else n_pass++;
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        xs   = '0;
        for (int i = 0; i < n; i++) begin
            g = int'($urandom_range(gap_max, gap_min));
            for (int k = 0; k < g; k++) begin
                host_valid = 1'b0;
                start      = noisy ? 1'($urandom) : 1'b0;
                host_last  = noisy ? 1'($urandom) : 1'b0;
                host_instr = IW'($urandom);
                n_checks++;
                if (pmem_le !== pend || (pend && (pmem_la !== pa || pmem_li !== pd)))
                    $display("FAIL gap_write: le=%b la=%0d li=%h required le=%b la=%0d li=%h",
                             pmem_le, pmem_la, pmem_li, pend, pa, pd);
                else n_pass++;
                pend = 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            n_checks++;
            if (pmem_le !== pend || (pend && (pmem_la !== pa || pmem_li !== pd)))
                $display("FAIL word_write: le=%b la=%0d li=%h required le=%b la=%0d li=%h",
                         pmem_le, pmem_la, pmem_li, pend, pa, pd);
            else n_pass++;
            n_checks++;
            if (host_ready !== 1'b1 || word_count !== AW'(i) || checksum !== xs)
                $display("FAIL load_progress: ready=%b cnt=%0d sum=%h required ready=1 cnt=%0d sum=%h",
                         host_ready, word_count, checksum, i, xs);
            else n_pass++;
            host_valid = 1'b1;
            host_instr = words[i];
            host_last  = use_last && (i == n - 1);
            pend = 1'b1;
            pa   = AW'(i);
            pd   = words[i];
            xs   = xs ^ words[i];
            @(negedge clk);
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        host_instr = IW'($urandom);
        n_checks++;
        if (pmem_le !== 1'b1 || pmem_la !== pa || pmem_li !== pd)
            $display("FAIL final_write: le=%b la=%0d li=%h required le=1 la=%0d li=%h",
                     pmem_le, pmem_la, pmem_li, pa, pd);
        else n_pass++;
        n_checks++;
        if (use_last && {host_ready, core_clr, core_rst, done, err} !== 5'b01100)
            $display("FAIL clear_cycle: ready/clr/rst/done/err=%b required 01100",
                     {host_ready, core_clr, core_rst, done, err});
        else if (!use_last && {host_ready, core_clr, core_rst, done, err} !== 5'b00101)
            $display("FAIL overflow: ready/clr/rst/done/err=%b required 00101",
                     {host_ready, core_clr, core_rst, done, err});
        else n_pass++;
        exp_count = AW'(n);
        exp_sum   = xs;
        @(negedge clk);
        n_checks++;
        if (pmem_le !== 1'b0 || word_count !== exp_count || checksum !== exp_sum)
            $display("FAIL load_result: le=%b cnt=%0d sum=%h required le=0 cnt=%0d sum=%h",
                     pmem_le, word_count, checksum, exp_count, exp_sum);
        else n_pass++;
        n_checks++;
        if (use_last && {host_ready, core_clr, core_rst, done, err} !== 5'b00010)
            $display("FAIL run_state: ready/clr/rst/done/err=%b required 00010",
                     {host_ready, core_clr, core_rst, done, err});
        else if (!use_last && {host_ready, core_clr, core_rst, done, err} !== 5'b00101)
            $display("FAIL error_hold: ready/clr/rst/done/err=%b required 00101",
                     {host_ready, core_clr, core_rst, done, err});
        else n_pass++;
    endtask

    // Host keeps offering words outside LOAD; nothing may be accepted or written.
    task automatic test_handshake(input int cycles, input logic exp_done);
        for (int c = 0; c < cycles; c++) begin
            host_valid = 1'b1;
            host_last  = 1'($urandom);
            host_instr = IW'($urandom);
            @(negedge clk);
            n_checks++;
            if (host_ready !== 1'b0 || pmem_le !== 1'b0 || done !== exp_done ||
                word_count !== exp_count || checksum !== exp_sum)
                $display("FAIL handshake_idle: ready=%b le=%b done=%b cnt=%0d sum=%h required 0 0 %b %0d %h",
                         host_ready, pmem_le, done, word_count, checksum, exp_done, exp_count, exp_sum);
            else n_pass++;
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        host_valid = 1'b0;
        host_last  = 1'b0;
        host_instr = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({host_ready, pmem_le, core_rst, core_clr, done, err} !== 6'b001000 ||
            pmem_la !== '0 || pmem_li !== '0 || word_count !== '0 || checksum !== '0)
            $display("FAIL reset_values: ready/le/rst/clr/done/err=%b la=%0d li=%h cnt=%0d sum=%h required 001000 0 000 0 000",
                     {host_ready, pmem_le, core_rst, core_clr, done, err}, pmem_la, pmem_li, word_count, checksum);
        else n_pass++;
        rst = 1'b0;
        exp_count = '0;
        exp_sum   = '0;
        test_handshake(3, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) words[i] = IW'(i + 1);
        do_load(DEPTH, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (word_count !== AW'(10) || checksum !== 12'h00B)
            $display("FAIL b2b_totals: cnt=%0d sum=%h required cnt=10 sum=00b", word_count, checksum);
        else n_pass++;
    endtask

    task automatic test_short_gapped();
        words[0] = 12'hA5F;
        words[1] = 12'h0F0;
        words[2] = 12'h123;
        do_load(3, 1'b1, 2, 2, 1'b0);
        n_checks++;
        if (checksum !== 12'hB8C || done !== 1'b1)
            $display("FAIL short_totals: sum=%h done=%b required sum=b8c done=1", checksum, done);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) words[i] = IW'($urandom);
        do_load(DEPTH, 1'b0, 0, 1, 1'b1);
        for (int i = 0; i < 3; i++) words[i] = IW'($urandom);
        do_load(3, 1'b1, 0, 1, 1'b0);
    endtask

    task automatic test_reload();
        words[0] = IW'($urandom);
        words[1] = IW'($urandom);
        do_load(2, 1'b1, 0, 2, 1'b0);
        n_checks++;
        if (word_count !== AW'(2))
            $display("FAIL reload_count: cnt=%0d required 2", word_count);
        else n_pass++;
    endtask

    task automatic test_rst_midload();
        for (int i = 0; i < 5; i++) words[i] = IW'($urandom);
        host_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_instr = words[i];
            host_last  = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (pmem_le !== 1'b1 || pmem_la !== AW'(3) || pmem_li !== words[3])
            $display("FAIL pre_rst_write: le=%b la=%0d li=%h required le=1 la=3 li=%h",
                     pmem_le, pmem_la, pmem_li, words[3]);
        else n_pass++;
        host_instr = words[4];
        rst        = 1'b1;
        start      = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({host_ready, pmem_le, core_rst, core_clr, done, err} !== 6'b001000 ||
                pmem_la !== '0 || pmem_li !== '0 || word_count !== '0 || checksum !== '0)
                $display("FAIL rst_midload: ready/le/rst/clr/done/err=%b la=%0d li=%h cnt=%0d sum=%h required 001000 0 000 0 000",
                         {host_ready, pmem_le, core_rst, core_clr, done, err}, pmem_la, pmem_li, word_count, checksum);
            else n_pass++;
        end
        rst        = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        exp_count  = '0;
        exp_sum    = '0;
        test_handshake(2, 1'b0);
    endtask

    task automatic test_random();
        bit ovf;
        int n;
        for (int it = 0; it < 16; it++) begin
            ovf = ($urandom_range(3, 0) == 0);
            n   = ovf ? DEPTH : int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < n; i++) words[i] = IW'($urandom);
            do_load(n, !ovf, 0, 3, 1'b1);
            if (!ovf && $urandom_range(1, 0) == 1) test_handshake(2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_handshake(4, 1'b1);
        test_short_gapped();
        test_overflow();
        test_reload();
        test_rst_midload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
